// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep run-control sequencer.
package sweep_pkg;

  localparam int unsigned CFG_LOG2_W   = 12;
  localparam int unsigned THRESH_W     = 32;
  localparam int unsigned MIN_FFT_LOG2 = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CFG_LOG2_W-1:0] fft_log2;
    logic                  win_en;
    logic [THRESH_W-1:0]   threshold;
  } sweep_cfg_t;

  // Keep the requested FFT size inside what the pipeline supports.
  function automatic logic [CFG_LOG2_W-1:0] clamp_log2(input logic [CFG_LOG2_W-1:0] req,
                                                       input logic [CFG_LOG2_W-1:0] max_log2);
    if (req < CFG_LOG2_W'(MIN_FFT_LOG2)) return CFG_LOG2_W'(MIN_FFT_LOG2);
    else if (req > max_log2)              return max_log2;
    else                                  return req;
  endfunction

endpackage

// File: rtl/frame_gate.sv
// Registered ADC sample gate with sample and frame counters; flags the final
// sample of the sweep so only whole frames reach the pipeline.
module frame_gate
  import sweep_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LOG2_W      = 12,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [LOG2_W-1:0]      fft_log2,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   abort_pend,
  input  logic                   valid_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   valid_out,
  output logic [DATA_W-1:0]      data_out,
  output logic [FRAME_CNT_W-1:0] in_frames,
  output logic                   frame_end
);

  localparam logic [LOG2_W-1:0] ONES = '1;

  logic [LOG2_W-1:0] sample_cnt;
  logic [LOG2_W-1:0] last_idx;
  logic              take;
  logic              wrap;
  logic              last_frame;

  assign last_idx   = ~(ONES << fft_log2);
  assign take       = enable & valid_in;
  assign wrap       = take && (sample_cnt == last_idx);
  assign last_frame = (num_frames != '0) && (FRAME_CNT_W'(in_frames + 1'b1) == num_frames);
  assign frame_end  = wrap && (last_frame || abort_pend);

  // Gate register and counters; data holds its last value while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      sample_cnt <= '0;
      in_frames  <= '0;
    end else begin
      valid_out <= take;
      if (enable) data_out <= data_in;
      if (clear) begin
        sample_cnt <= '0;
        in_frames  <= '0;
      end else if (take) begin
        sample_cnt <= wrap ? '0 : LOG2_W'(sample_cnt + 1'b1);
        if (wrap) in_frames <= FRAME_CNT_W'(in_frames + 1'b1);
      end
    end
  end

endmodule

// File: rtl/sweep_scheduler.sv
// Run-control sequencer: latches a sweep configuration, gates whole ADC frames,
// counts detector frames and signals completion or drain timeout.
module sweep_scheduler
  import sweep_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FFT_MAX_LOG2 = 12,
  parameter int unsigned FRAME_CNT_W  = 16,
  parameter int unsigned TIMEOUT_W    = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_start,
  input  logic                    sw_abort,
  input  logic [FFT_MAX_LOG2-1:0] sw_fft_log2,
  input  logic                    sw_win_en,
  input  logic [31:0]             sw_threshold,
  input  logic [FRAME_CNT_W-1:0]  sw_num_frames,
  input  logic [TIMEOUT_W-1:0]    sw_timeout,
  input  logic                    adc_valid_in,
  input  logic [DATA_W-1:0]       adc_data_in,
  output logic                    adc_valid_out,
  output logic [DATA_W-1:0]       adc_data_out,
  output logic [FFT_MAX_LOG2-1:0] cfg_fft_log2,
  output logic                    cfg_win_en,
  output logic [31:0]             cfg_threshold,
  input  logic                    mon_det_valid,
  input  logic                    mon_det_ready,
  input  logic                    mon_det_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic [FRAME_CNT_W-1:0]  frames_done
);

  state_t                 state, state_nxt;
  sweep_cfg_t             cfg_q, cfg_d;
  logic [FRAME_CNT_W-1:0] num_frames_q, in_frames, fd_nxt;
  logic [TIMEOUT_W-1:0]   timeout_q, tmo_cnt, tmo_nxt;
  logic                   abort_pend_q, frame_end;
  logic                   gate_en, gate_clr, latch_cfg;
  logic                   det_beat, det_last_beat, complete, tmo_hit;

  assign cfg_fft_log2  = FFT_MAX_LOG2'(cfg_q.fft_log2);
  assign cfg_win_en    = cfg_q.win_en;
  assign cfg_threshold = cfg_q.threshold;

  assign det_beat      = mon_det_valid & mon_det_ready;
  assign det_last_beat = det_beat & mon_det_last;
  assign fd_nxt   = (det_last_beat && frames_done != '1) ? FRAME_CNT_W'(frames_done + 1'b1)
                                                         : frames_done;
  assign complete = (fd_nxt == in_frames);
  assign tmo_nxt  = det_beat ? '0 : TIMEOUT_W'(tmo_cnt + 1'b1);
  assign tmo_hit  = (timeout_q != '0) && (tmo_nxt == timeout_q);

  always_comb begin
    cfg_d.fft_log2  = clamp_log2(CFG_LOG2_W'(sw_fft_log2), CFG_LOG2_W'(FFT_MAX_LOG2));
    cfg_d.win_en    = sw_win_en;
    cfg_d.threshold = sw_threshold;
  end

  // State register; busy/done are flopped from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sw_start) state_nxt = ARM;
      ARM:     state_nxt = CAPTURE;
      CAPTURE: if (frame_end) state_nxt = DRAIN;
      DRAIN:   if (complete || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gate_en   = 1'b0;
    gate_clr  = 1'b0;
    latch_cfg = 1'b0;
    unique case (state)
      ARM: begin
        latch_cfg = 1'b1;
        gate_clr  = 1'b1;
      end
      CAPTURE: gate_en = 1'b1;
      default: ;
    endcase
  end

  // Sweep configuration, frame monitor and drain timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q.fft_log2  <= CFG_LOG2_W'(FFT_MAX_LOG2);
      cfg_q.win_en    <= 1'b0;
      cfg_q.threshold <= '0;
      num_frames_q    <= '0;
      timeout_q       <= '0;
      abort_pend_q    <= 1'b0;
      frames_done     <= '0;
      tmo_cnt         <= '0;
      err_timeout     <= 1'b0;
    end else begin
      if (state == IDLE && sw_start) begin
        err_timeout <= 1'b0;
        frames_done <= '0;
      end
      if (latch_cfg) begin
        cfg_q        <= cfg_d;
        num_frames_q <= sw_num_frames;
        timeout_q    <= sw_timeout;
        abort_pend_q <= 1'b0;
      end
      if (state == CAPTURE && sw_abort) abort_pend_q <= 1'b1;
      if (state == CAPTURE || state == DRAIN) frames_done <= fd_nxt;
      tmo_cnt <= (state == DRAIN) ? tmo_nxt : '0;
      if (state == DRAIN && !complete && tmo_hit) err_timeout <= 1'b1;
    end
  end

  frame_gate #(
    .DATA_W      (DATA_W),
    .LOG2_W      (FFT_MAX_LOG2),
    .FRAME_CNT_W (FRAME_CNT_W)
  ) u_frame_gate (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (gate_en),
    .clear      (gate_clr),
    .fft_log2   (cfg_fft_log2),
    .num_frames (num_frames_q),
    .abort_pend (abort_pend_q | sw_abort),
    .valid_in   (adc_valid_in),
    .data_in    (adc_data_in),
    .valid_out  (adc_valid_out),
    .data_out   (adc_data_out),
    .in_frames  (in_frames),
    .frame_end  (frame_end)
  );

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed sweeps with randomized sample data/gaps, checked against a
// frame-level model of gated samples, done timing and status.
module tb_sweep_scheduler;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned FFT_MAX_LOG2 = 12;
  localparam int unsigned FRAME_CNT_W  = 16;
  localparam int unsigned TIMEOUT_W    = 20;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sw_start, sw_abort, sw_win_en;
  logic [FFT_MAX_LOG2-1:0] sw_fft_log2;
  logic [31:0]             sw_threshold;
  logic [FRAME_CNT_W-1:0]  sw_num_frames;
  logic [TIMEOUT_W-1:0]    sw_timeout;
  logic                    adc_valid_in;
  logic [DATA_W-1:0]       adc_data_in;
  logic                    adc_valid_out;
  logic [DATA_W-1:0]       adc_data_out;
  logic [FFT_MAX_LOG2-1:0] cfg_fft_log2;
  logic                    cfg_win_en;
  logic [31:0]             cfg_threshold;
  logic                    mon_det_valid, mon_det_ready, mon_det_last;
  logic                    busy, done, err_timeout;
  logic [FRAME_CNT_W-1:0]  frames_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] out_q[$];
  int                done_q[$];

  sweep_scheduler #(
    .DATA_W(DATA_W), .FFT_MAX_LOG2(FFT_MAX_LOG2),
    .FRAME_CNT_W(FRAME_CNT_W), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_start(sw_start), .sw_abort(sw_abort),
    .sw_fft_log2(sw_fft_log2), .sw_win_en(sw_win_en), .sw_threshold(sw_threshold),
    .sw_num_frames(sw_num_frames), .sw_timeout(sw_timeout),
    .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
    .adc_valid_out(adc_valid_out), .adc_data_out(adc_data_out),
    .cfg_fft_log2(cfg_fft_log2), .cfg_win_en(cfg_win_en), .cfg_threshold(cfg_threshold),
    .mon_det_valid(mon_det_valid), .mon_det_ready(mon_det_ready), .mon_det_last(mon_det_last),
    .busy(busy), .done(done), .err_timeout(err_timeout), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record gated samples and done pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (adc_valid_out === 1'b1) out_q.push_back(adc_data_out);
    if (done === 1'b1) done_q.push_back(cyc);
  endtask

  function automatic int clamp_model(input int r);
    if (r < 3) return 3;
    if (r > 12) return 12;
    return r;
  endfunction

  task automatic sweep(input string tag, input int l2, input int nf, input int abort_at,
                       input int tmo, input bit use_det, input bit gaps, input logic [31:0] thr);
    int   l2e, flen, nfe, n, sent, extra, c_last, c_det, exp_done, bad, got;
    bit   v, win;
    l2e    = clamp_model(l2);
    flen   = 1 << l2e;
    nfe    = (abort_at > 0) ? (abort_at + flen - 1) / flen : nf;
    n      = nfe * flen;
    c_last = 0;
    c_det  = 0;
    in_q.delete(); out_q.delete(); done_q.delete();
    win           = 1'($urandom_range(0, 1));
    sw_fft_log2   = FFT_MAX_LOG2'(l2);
    sw_win_en     = win;
    sw_threshold  = thr;
    sw_num_frames = FRAME_CNT_W'(nf);
    sw_timeout    = TIMEOUT_W'(tmo);
    sw_start      = 1'b1;
    sw_abort      = 1'b1;  // must be dropped: start wins in IDLE
    step();
    sw_start = 1'b0;
    sw_abort = 1'b0;
    chk({tag, ":busy_arm"}, 64'(busy), 64'd1);
    chk({tag, ":frames_done_clr"}, 64'(frames_done), 64'd0);
    chk({tag, ":err_clr"}, 64'(err_timeout), 64'd0);
    step();
    chk({tag, ":cfg_fft_log2"}, 64'(cfg_fft_log2), 64'(l2e));
    chk({tag, ":cfg_win_en"}, 64'(cfg_win_en), 64'(win));
    chk({tag, ":cfg_threshold"}, 64'(cfg_threshold), 64'(thr));
    sw_threshold = thr + 32'd100;
    sent  = 0;
    extra = 0;
    while (extra < 6) begin
      v            = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      adc_valid_in = v;
      adc_data_in  = DATA_W'($urandom);
      sw_abort     = 1'b0;
      if (v) begin
        if (sent < n) begin
          in_q.push_back(adc_data_in);
          sent++;
          if (sent == abort_at) sw_abort = 1'b1;
          if (sent == n) c_last = cyc;
        end else begin
          extra++;
        end
      end
      step();
    end
    adc_valid_in = 1'b0;
    sw_abort     = 1'b0;
    step();
    step();
    chk({tag, ":gated_count"}, 64'(out_q.size()), 64'(n));
    bad = 0;
    for (int i = 0; i < out_q.size() && i < in_q.size(); i++)
      if (out_q[i] !== in_q[i]) bad++;
    chk({tag, ":gated_data_errs"}, 64'(bad), 64'd0);
    chk({tag, ":cfg_thr_held"}, 64'(cfg_threshold), 64'(thr));
    if (use_det) begin
      for (int f = 0; f < nfe; f++) begin
        mon_det_valid = 1'b1; mon_det_ready = 1'b1; mon_det_last = 1'b0;
        step();
        mon_det_ready = 1'b0; mon_det_last = 1'b1;  // not a beat: ready low
        step();
        mon_det_valid = 1'b0;
        step();
        mon_det_valid = 1'b1; mon_det_ready = 1'b1; mon_det_last = 1'b1;
        c_det = cyc;
        step();
        mon_det_valid = 1'b0; mon_det_ready = 1'b0; mon_det_last = 1'b0;
        if (f < nfe - 1) chk({tag, ":no_early_done"}, 64'(done_q.size()), 64'd0);
      end
      exp_done = c_det + 1;
    end else begin
      exp_done = c_last + 1 + tmo;
    end
    for (int i = 0; i < tmo + 64; i++) begin
      if (done_q.size() != 0) break;
      step();
    end
    step();
    step();
    got = (done_q.size() > 0) ? done_q[0] : -1;
    chk({tag, ":done_pulses"}, 64'(done_q.size()), 64'd1);
    chk({tag, ":done_cycle"}, 64'(got), 64'(exp_done));
    chk({tag, ":frames_done"}, 64'(frames_done), use_det ? 64'(nfe) : 64'd0);
    chk({tag, ":err_timeout"}, 64'(err_timeout), use_det ? 64'd0 : 64'd1);
    chk({tag, ":busy_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_start = 1'b0; sw_abort = 1'b0; sw_win_en = 1'b0;
    sw_fft_log2 = '0; sw_threshold = '0; sw_num_frames = '0; sw_timeout = '0;
    adc_valid_in = 1'b0; adc_data_in = '0;
    mon_det_valid = 1'b0; mon_det_ready = 1'b0; mon_det_last = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset:adc_valid_out", 64'(adc_valid_out), 64'd0);
    chk("reset:adc_data_out", 64'(adc_data_out), 64'd0);
    chk("reset:cfg_fft_log2", 64'(cfg_fft_log2), 64'(FFT_MAX_LOG2));
    chk("reset:cfg_win_en", 64'(cfg_win_en), 64'd0);
    chk("reset:cfg_threshold", 64'(cfg_threshold), 64'd0);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:err_timeout", 64'(err_timeout), 64'd0);
    chk("reset:frames_done", 64'(frames_done), 64'd0);

    sweep("basic",   4, 2, 0,  0,   1'b1, 1'b0, 32'd100);
    sweep("clamplo", 1, 1, 0,  300, 1'b1, 1'b1, 32'd200);
    sweep("clamphi", 15, 1, 0, 300, 1'b1, 1'b1, $urandom);
    sweep("abort",   3, 0, 21, 0,   1'b1, 1'b1, $urandom);
    sweep("timeout", 5, 1, 0,  10,  1'b0, 1'b0, $urandom);
    sweep("rand",    $urandom_range(3, 6), $urandom_range(1, 3), 0, 300, 1'b1, 1'b1, $urandom);

    // Asynchronous reset in the middle of CAPTURE.
    sw_fft_log2 = FFT_MAX_LOG2'(5); sw_num_frames = '0; sw_timeout = '0;
    sw_threshold = 32'h1234_5678; sw_start = 1'b1;
    step();
    sw_start = 1'b0;
    step();
    adc_valid_in = 1'b1;
    adc_data_in  = 16'hbeef;
    repeat (6) step();
    chk("midrst:pre_valid", 64'(adc_valid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:adc_valid_out", 64'(adc_valid_out), 64'd0);
    chk("midrst:adc_data_out", 64'(adc_data_out), 64'd0);
    chk("midrst:busy", 64'(busy), 64'd0);
    chk("midrst:cfg_fft_log2", 64'(cfg_fft_log2), 64'(FFT_MAX_LOG2));
    chk("midrst:cfg_threshold", 64'(cfg_threshold), 64'd0);
    adc_valid_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("midrst:idle_after", 64'(busy), 64'd0);

    sweep("post_rst", 3, 2, 0, 300, 1'b1, 1'b1, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
